pd_reset_ordered_set_tx: RTL and testbench



---
 rtl/pd_reset_ordered_set_tx.sv | 145 ++++++++++++++
 tb/tb_pd_reset_ordered_set_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pd_reset_ordered_set_tx.sv
// Hard/Cable Reset ordered-set transmitter: waits for an idle CC line, sends preamble plus four K-codes, then reports.
// Optional build macro BMC_ENCODE_EN selects Biphase Mark Coded line data instead of raw NRZ.
module pd_reset_ordered_set_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PREAMBLE_LEN = 64,
    parameter int IDLE_TIMEOUT = 900
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [7:0]  iTRANSMIT,
    input  logic        iTransmit_Valid,
    input  logic        iCC_Busy,
    input  logic        iPHY_Stop_Attempting_Reset,
    output logic        oTX_Data,
    output logic        oTX_Enable,
    output logic        oBusy,
    output logic [15:0] oAlert_Set
);

    localparam int FRAME_BITS = PREAMBLE_LEN + 20;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int CLK_W      = $clog2(CLKS_PER_BIT);
    localparam int WAIT_W     = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [CLK_W-1:0]  CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  PRE_LAST  = BIT_W'(PREAMBLE_LEN - 1);
    localparam logic [BIT_W-1:0]  FRM_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0]  PRE_BITS  = BIT_W'(PREAMBLE_LEN);
    localparam logic [WAIT_W-1:0] WAIT_TERM = WAIT_W'(IDLE_TIMEOUT);

    localparam logic [4:0] K_RST1  = 5'b00111;
    localparam logic [4:0] K_RST2  = 5'b11001;
    localparam logic [4:0] K_SYNC1 = 5'b11000;
    localparam logic [4:0] K_SYNC3 = 5'b00110;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_IDLE, S_PREAMBLE, S_ORDERED_SET, S_REPORT_OK, S_REPORT_FAIL
    } state_t;

    state_t            r_state, w_state_next;
    logic              r_cable, w_cable_next;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_next, w_wait_inc;
    logic [CLK_W-1:0]  r_clk_cnt, w_clk_next;
    logic [BIT_W-1:0]  r_bit_cnt, w_bit_next;
    logic              r_tx_data, r_tx_en, r_busy;
    logic [15:0]       r_alert;

    logic              w_period_end, w_driving_next, w_raw_bit, w_data_next;
    logic [15:0]       w_alert_next;
    logic [19:0]       w_os_pattern;
    logic [4:0]        w_os_off;
    logic              w_unused_cmd_bits;

    assign w_unused_cmd_bits = ^iTRANSMIT[7:3];
    assign w_wait_inc        = r_wait_cnt + 1'b1;
    assign w_period_end      = (r_clk_cnt == CLK_LAST);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cable    <= 1'b0;
            r_wait_cnt <= '0;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx_data  <= 1'b0;
            r_tx_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_alert    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cable    <= w_cable_next;
            r_wait_cnt <= w_wait_next;
            r_clk_cnt  <= w_clk_next;
            r_bit_cnt  <= w_bit_next;
            r_tx_data  <= w_data_next;
            r_tx_en    <= w_driving_next;
            r_busy     <= (w_state_next != S_IDLE);
            r_alert    <= w_alert_next;
        end
    end

    // Abort is tested before the bit-period terminal check so it wins a tie.
    always_comb begin
        w_state_next = r_state;
        w_cable_next = r_cable;
        w_wait_next  = '0;
        w_clk_next   = '0;
        w_bit_next   = '0;
        case (r_state)
            S_IDLE: begin
                if (iTransmit_Valid && (iTRANSMIT[2:0] == 3'b101 || iTRANSMIT[2:0] == 3'b110)) begin
                    w_state_next = S_WAIT_IDLE;
                    w_cable_next = iTRANSMIT[1];
                end
            end
            S_WAIT_IDLE: begin
                if (iPHY_Stop_Attempting_Reset)  w_state_next = S_REPORT_FAIL;
                else if (!iCC_Busy)              w_state_next = S_PREAMBLE;
                else if (w_wait_inc == WAIT_TERM) w_state_next = S_REPORT_FAIL;
                else                              w_wait_next  = w_wait_inc;
            end
            S_PREAMBLE, S_ORDERED_SET: begin
                w_clk_next = w_period_end ? '0 : r_clk_cnt + 1'b1;
                w_bit_next = w_period_end ? r_bit_cnt + 1'b1 : r_bit_cnt;
                if (iPHY_Stop_Attempting_Reset)
                    w_state_next = S_REPORT_FAIL;
                else if (r_state == S_PREAMBLE && w_period_end && r_bit_cnt == PRE_LAST)
                    w_state_next = S_ORDERED_SET;
                else if (r_state == S_ORDERED_SET && w_period_end && r_bit_cnt == FRM_LAST)
                    w_state_next = S_REPORT_OK;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_state_next != S_PREAMBLE && w_state_next != S_ORDERED_SET) begin
            w_clk_next = '0;
            w_bit_next = '0;
        end
    end

    // Outputs are computed from next-state values so the registered pins line up with the state register.
    always_comb begin
        w_driving_next = (w_state_next == S_PREAMBLE) || (w_state_next == S_ORDERED_SET);
        w_alert_next   = '0;
        if (w_state_next == S_REPORT_OK)   w_alert_next[6] = 1'b1;
        if (w_state_next == S_REPORT_FAIL) w_alert_next[4] = 1'b1;
        w_os_pattern = r_cable ? {K_SYNC3, K_RST1, K_SYNC1, K_RST1}
                               : {K_RST2,  K_RST1, K_RST1,  K_RST1};
        w_os_off  = 5'(w_bit_next - PRE_BITS);
        w_raw_bit = (w_bit_next < PRE_BITS) ? w_bit_next[0] : w_os_pattern[w_os_off];
`ifdef BMC_ENCODE_EN
        w_data_next = w_driving_next
                    ? r_tx_data ^ ((w_clk_next == '0) ||
                                   (w_raw_bit && w_clk_next == CLK_W'(CLKS_PER_BIT / 2)))
                    : 1'b0;
`else
        w_data_next = w_driving_next & w_raw_bit;
`endif
    end

    assign oTX_Data   = r_tx_data;
    assign oTX_Enable = r_tx_en;
    assign oBusy      = r_busy;
    assign oAlert_Set = r_alert;

endmodule

// File: tb/tb_pd_reset_ordered_set_tx.sv
// Randomized self-checking bench for pd_reset_ordered_set_tx; expected bit streams come from a K-code table model.
module tb_pd_reset_ordered_set_tx;

    localparam int CPB = 4;
    localparam int PL  = 64;
    localparam int TO  = 900;
    localparam int NB  = PL + 20;
    localparam int CAP = NB * CPB + 64;

    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  iTRANSMIT;
    logic        iTransmit_Valid, iCC_Busy, iPHY_Stop_Attempting_Reset;
    logic        oTX_Data, oTX_Enable, oBusy;
    logic [15:0] oAlert_Set;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic cap [0:CAP-1];

    always #5 CLK = ~CLK;

    pd_reset_ordered_set_tx #(.CLKS_PER_BIT(CPB), .PREAMBLE_LEN(PL), .IDLE_TIMEOUT(TO)) dut (
        .CLK(CLK), .reset(reset), .iTRANSMIT(iTRANSMIT), .iTransmit_Valid(iTransmit_Valid),
        .iCC_Busy(iCC_Busy), .iPHY_Stop_Attempting_Reset(iPHY_Stop_Attempting_Reset),
        .oTX_Data(oTX_Data), .oTX_Enable(oTX_Enable), .oBusy(oBusy), .oAlert_Set(oAlert_Set));

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Reference: preamble alternates from 0, then the K-code table for the command, LSB first.
    function automatic logic [4:0] ref_kcode(input int k, input logic cable);
        logic [4:0] c;
        case (k)
            0:       c = 5'b00111;
            1:       c = cable ? 5'b11000 : 5'b00111;
            2:       c = 5'b00111;
            default: c = cable ? 5'b00110 : 5'b11001;
        endcase
        return c;
    endfunction

    function automatic logic [NB-1:0] ref_stream(input logic cable);
        logic [NB-1:0] s;
        logic [4:0]    c;
        for (int i = 0; i < NB; i++) begin
            if (i < PL) s[i] = logic'(i % 2);
            else begin
                c    = ref_kcode((i - PL) / 5, cable);
                s[i] = c[(i - PL) % 5];
            end
        end
        return s;
    endfunction

    task automatic capture_frame(output int n_en);
        n_en = 0;
        while (oTX_Enable === 1'b1 && n_en < 2000) begin
            if (n_en < CAP) cap[n_en] = oTX_Data;
            n_en++;
            tick();
        end
    endtask

    task automatic decode_capture(output logic [NB-1:0] bits, output int shape_err);
        logic prev, l0, mid;
        shape_err = 0;
        for (int i = 0; i < NB; i++) begin
`ifdef BMC_ENCODE_EN
            prev = (i == 0) ? 1'b0 : cap[i*CPB-1];
            l0   = cap[i*CPB];
            mid  = cap[i*CPB + CPB/2];
            if (l0 === prev) shape_err++;
            for (int c = 1; c < CPB; c++)
                if (c != CPB/2 && cap[i*CPB+c] !== cap[i*CPB+c-1]) shape_err++;
            bits[i] = l0 ^ mid;
`else
            l0 = cap[i*CPB];
            for (int c = 1; c < CPB; c++)
                if (cap[i*CPB+c] !== l0) shape_err++;
            bits[i] = l0;
`endif
        end
    endtask

    task automatic strobe(input logic [7:0] code);
        iTRANSMIT       = code;
        iTransmit_Valid = 1'b1;
        tick();
        iTransmit_Valid = 1'b0;
        iTRANSMIT       = 8'($urandom);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (oTX_Enable !== 1'b0 || oTX_Data !== 1'b0) begin n_fail++; $display("FAIL reset_line: got en=%b data=%b expected 0 0", oTX_Enable, oTX_Data); end
        n_checks++; if (oBusy !== 1'b0 || oAlert_Set !== 16'h0) begin n_fail++; $display("FAIL reset_status: got busy=%b alert=%h expected 0 0000", oBusy, oAlert_Set); end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", oBusy); end
        $display("reset: busy=%b en=%b alert=%h", oBusy, oTX_Enable, oAlert_Set);
    endtask

    task automatic test_frame(input logic cable, input string name);
        logic [7:0]    code;
        logic [NB-1:0] got, exp;
        int            n_en, shape_err;
        code = {3'($urandom), 2'b00, 3'b000};
        code[2:0] = cable ? 3'b110 : 3'b101;
        iCC_Busy = 1'b0;
        strobe(code);
        n_checks++; if (oTX_Enable !== 1'b0 || oBusy !== 1'b1) begin n_fail++; $display("FAIL %s strobe_cycle: got en=%b busy=%b expected 0 1", name, oTX_Enable, oBusy); end
        tick();
        n_checks++; if (oTX_Enable !== 1'b1) begin n_fail++; $display("FAIL %s enable_rise: got %b expected 1", name, oTX_Enable); end
        capture_frame(n_en);
        n_checks++; if (n_en != NB * CPB) begin n_fail++; $display("FAIL %s enable_cycles: got %0d expected %0d", name, n_en, NB * CPB); end
        n_checks++; if (oAlert_Set !== 16'h0040 || oTX_Data !== 1'b0) begin n_fail++; $display("FAIL %s ok_alert: got alert=%h data=%b expected 0040 0", name, oAlert_Set, oTX_Data); end
        tick();
        n_checks++; if (oAlert_Set !== 16'h0 || oBusy !== 1'b0) begin n_fail++; $display("FAIL %s post_alert: got alert=%h busy=%b expected 0000 0", name, oAlert_Set, oBusy); end
        decode_capture(got, shape_err);
        exp = ref_stream(cable);
        n_checks++; if (shape_err != 0) begin n_fail++; $display("FAIL %s bit_shape: got %0d bad edges expected 0", name, shape_err); end
        n_checks++; if (got[PL-1:0] !== exp[PL-1:0]) begin n_fail++; $display("FAIL %s preamble: got %h expected %h", name, got[PL-1:0], exp[PL-1:0]); end
        n_checks++; if (got[NB-1:PL] !== exp[NB-1:PL]) begin n_fail++; $display("FAIL %s ordered_set: got %b expected %b", name, got[NB-1:PL], exp[NB-1:PL]); end
        $display("%s: code=%h en_cycles=%0d os=%b", name, code, n_en, got[NB-1:PL]);
    endtask

    task automatic test_busy_timeout;
        int   n;
        logic saw_en;
        iCC_Busy = 1'b1;
        strobe({5'($urandom), 3'b101});
        n = 0; saw_en = 1'b0;
        while (oAlert_Set === 16'h0 && n < 2000) begin
            tick();
            n++;
            if (oTX_Enable !== 1'b0) saw_en = 1'b1;
        end
        n_checks++; if (n != TO) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TO); end
        n_checks++; if (oAlert_Set !== 16'h0010) begin n_fail++; $display("FAIL timeout_alert: got %h expected 0010", oAlert_Set); end
        n_checks++; if (saw_en !== 1'b0) begin n_fail++; $display("FAIL timeout_enable: got %b expected 0", saw_en); end
        tick();
        n_checks++; if (oBusy !== 1'b0 || oAlert_Set !== 16'h0) begin n_fail++; $display("FAIL timeout_idle: got busy=%b alert=%h expected 0 0000", oBusy, oAlert_Set); end
        iCC_Busy = 1'b0;
        $display("busy_timeout: wait_cycles=%0d", n);
    endtask

    task automatic test_busy_delay;
        int d, n, n_en;
        d = $urandom_range(1, 40);
        iCC_Busy = 1'b1;
        strobe({5'($urandom), 3'b110});
        repeat (d) tick();
        iCC_Busy = 1'b0;
        n = d;
        while (oTX_Enable !== 1'b1 && n < 200) begin tick(); n++; end
        n_checks++; if (n != d + 1) begin n_fail++; $display("FAIL busy_delay_start: got %0d expected %0d", n, d + 1); end
        iCC_Busy = 1'b1;   // ignored once transmitting
        capture_frame(n_en);
        iCC_Busy = 1'b0;
        n_checks++; if (n_en != NB * CPB || oAlert_Set !== 16'h0040) begin n_fail++; $display("FAIL busy_delay_frame: got cycles=%0d alert=%h expected %0d 0040", n_en, oAlert_Set, NB * CPB); end
        tick();
        $display("busy_delay: busy_cycles=%0d start_after=%0d en_cycles=%0d", d, n, n_en);
    endtask

    task automatic test_abort(input int abort_cycle, input string name);
        int extra;
        iCC_Busy = 1'b0;
        strobe(8'h05);
        tick();
        for (int j = 0; j < abort_cycle; j++) begin
            iTransmit_Valid = (j == abort_cycle / 2);
            iTRANSMIT       = 8'h05;
            tick();
        end
        iTransmit_Valid = 1'b0;
        n_checks++; if (oTX_Enable !== 1'b1) begin n_fail++; $display("FAIL %s pre_abort_enable: got %b expected 1", name, oTX_Enable); end
        iPHY_Stop_Attempting_Reset = 1'b1;
        tick();
        iPHY_Stop_Attempting_Reset = 1'b0;
        n_checks++; if (oTX_Enable !== 1'b0 || oTX_Data !== 1'b0) begin n_fail++; $display("FAIL %s abort_release: got en=%b data=%b expected 0 0", name, oTX_Enable, oTX_Data); end
        n_checks++; if (oAlert_Set !== 16'h0010) begin n_fail++; $display("FAIL %s abort_alert: got %h expected 0010", name, oAlert_Set); end
        tick();
        extra = 0;
        repeat (40) begin
            if (oTX_Enable !== 1'b0 || oBusy !== 1'b0 || oAlert_Set !== 16'h0) extra++;
            tick();
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL %s after_abort_activity: got %0d cycles expected 0", name, extra); end
        $display("%s: abort_cycle=%0d bit=%0d", name, abort_cycle, abort_cycle / CPB);
    endtask

    task automatic test_ignored_inputs;
        int act;
        logic [2:0] lo;
        act = 0;
        iPHY_Stop_Attempting_Reset = 1'b1;
        repeat (5) begin
            if (oBusy !== 1'b0 || oAlert_Set !== 16'h0) act++;
            tick();
        end
        iPHY_Stop_Attempting_Reset = 1'b0;
        n_checks++; if (act != 0) begin n_fail++; $display("FAIL idle_abort: got %0d active cycles expected 0", act); end
        for (int t = 0; t < 6; t++) begin
            lo = (t == 0) ? 3'b011 : 3'($urandom);
            while (lo == 3'b101 || lo == 3'b110) lo = 3'($urandom);
            act = 0;
            strobe({5'($urandom), lo});
            repeat (5) begin
                if (oBusy !== 1'b0 || oTX_Enable !== 1'b0 || oAlert_Set !== 16'h0) act++;
                tick();
            end
            n_checks++; if (act != 0) begin n_fail++; $display("FAIL invalid_code_%0d: got %0d active cycles expected 0", lo, act); end
            $display("invalid_code: low3=%b active_cycles=%0d", lo, act);
        end
    endtask

    task automatic test_reset_mid_frame;
        strobe(8'h06);
        tick();
        repeat (PL * CPB + 30) tick();
        n_checks++; if (oTX_Enable !== 1'b1) begin n_fail++; $display("FAIL midreset_in_frame: got en=%b expected 1", oTX_Enable); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (oTX_Enable !== 1'b0 || oTX_Data !== 1'b0 || oBusy !== 1'b0 || oAlert_Set !== 16'h0) begin
            n_fail++; $display("FAIL midreset_async: got en=%b data=%b busy=%b alert=%h expected all 0", oTX_Enable, oTX_Data, oBusy, oAlert_Set);
        end
        tick(); tick();
        #2 reset = 1'b1;
        tick(); tick();
        n_checks++; if (oBusy !== 1'b0 || oTX_Enable !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got busy=%b en=%b expected 0 0", oBusy, oTX_Enable); end
        $display("reset_mid_frame: busy=%b en=%b", oBusy, oTX_Enable);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        iTRANSMIT = 8'h00;
        iTransmit_Valid = 1'b0;
        iCC_Busy = 1'b0;
        iPHY_Stop_Attempting_Reset = 1'b0;
        test_reset();
        test_frame(1'b0, "hard_reset");
        test_frame(1'b1, "cable_reset");
        test_busy_timeout();
        test_busy_delay();
        test_abort(10 * CPB + int'($urandom_range(0, CPB - 1)), "abort_bit10");
        test_abort(int'($urandom_range(1, NB * CPB - 2)), "abort_random");
        test_abort(NB * CPB - 1, "abort_last_cycle");
        test_ignored_inputs();
        test_reset_mid_frame();
        test_frame(1'b0, "hard_after_reset");
        test_frame(1'b1, "cable_after_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
